bpu_update_sched: RTL

Schedules backend branch-predictor training updates (BHT counter bumps and BTB entry writes) onto the single-ported BHT/BTB arrays inside `bpu`, which the fetch path also uses for lookups. Sits between the backend commit logic and the `bpu` write interface in the frontend. Updates are queued in a small FIFO and issued in cycles with no fetch lookup. A starvation counter forces an update through, stalling fetch for one cycle, when lookups monopolise the port.

---
 rtl/bpu_update_sched.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/bpu_update_sched.sv
// -----------------------------------------------------------------------------
// bpu_update_sched
//
// Queues backend branch-predictor training updates (BHT counter bumps and BTB
// entry writes) and issues them onto the single-ported BHT/BTB arrays in `bpu`.
// An update issues in any cycle without a fetch lookup. If lookups keep the
// port busy for STARVE_LIMIT consecutive cycles while an update is waiting,
// the next cycle is forced: the update takes the port and fetch is stalled.
//
// Ports
//   clock, reset            : rising-edge clock, asynchronous active-high reset
//   fetch_req               : fetch lookup wants the BHT/BTB port this cycle
//   fetch_stall             : a forced update owns the port this cycle
//   upd_valid / upd_ready   : update push handshake
//   upd_bht_*               : BHT update payload (enable, index, select, inc, dec)
//   upd_btb_*               : BTB update payload (enable, index, wmask, din)
//   bht_write_*, bht_valid_in              : BHT write port of `bpu`
//   btb_ce, btb_we, btb_wmask,
//   btb_write_index, btb_din               : BTB write port of `bpu`
//   q_count                 : current queue occupancy
// -----------------------------------------------------------------------------
module bpu_update_sched #(
  parameter int QDEPTH       = 4,  // power of two, >= 2
  parameter int STARVE_LIMIT = 8   // 1..255
) (
  input  logic                        clock,
  input  logic                        reset,

  input  logic                        fetch_req,
  output logic                        fetch_stall,

  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic                        upd_bht_en,
  input  logic [8:0]                  upd_bht_index,
  input  logic [1:0]                  upd_bht_sel,
  input  logic                        upd_bht_inc,
  input  logic                        upd_bht_dec,
  input  logic                        upd_btb_en,
  input  logic [8:0]                  upd_btb_index,
  input  logic [128:0]                upd_btb_wmask,
  input  logic [128:0]                upd_btb_din,

  output logic                        bht_write_enable,
  output logic [8:0]                  bht_write_index,
  output logic [1:0]                  bht_write_counter_select,
  output logic                        bht_write_inc,
  output logic                        bht_write_dec,
  output logic                        bht_valid_in,

  output logic                        btb_ce,
  output logic                        btb_we,
  output logic [128:0]                btb_wmask,
  output logic [8:0]                  btb_write_index,
  output logic [128:0]                btb_din,

  output logic [$clog2(QDEPTH+1)-1:0] q_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  localparam logic [CW-1:0] FULL_COUNT = CW'(QDEPTH);
  localparam logic [7:0]    LIMIT      = 8'(STARVE_LIMIT);

  // Full update payload as held in the queue.
  typedef struct packed {
    logic         bht_en;
    logic [8:0]   bht_index;
    logic [1:0]   bht_sel;
    logic         bht_inc;
    logic         bht_dec;
    logic         btb_en;
    logic [8:0]   btb_index;
    logic [128:0] btb_wmask;
    logic [128:0] btb_din;
  } entry_t;

  entry_t          mem [QDEPTH];
  entry_t          wr_entry;
  entry_t          head;

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      starve_cnt;

  logic            not_empty;
  logic            forced;
  logic            grant;
  logic            push;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  assign not_empty   = (count != '0);
  assign forced      = (starve_cnt == LIMIT);
  // A forced cycle wins the port regardless of fetch_req.
  assign grant       = not_empty && (!fetch_req || forced);
  // No pass-through when full: readiness depends only on the registered count.
  assign upd_ready   = (count != FULL_COUNT);
  assign push        = upd_valid && upd_ready;
  assign fetch_stall = forced && not_empty;
  assign q_count     = count;

  assign head = mem[rd_ptr];

  always_comb begin
    wr_entry           = '0;
    wr_entry.bht_en    = upd_bht_en;
    wr_entry.bht_index = upd_bht_index;
    wr_entry.bht_sel   = upd_bht_sel;
    wr_entry.bht_inc   = upd_bht_inc;
    wr_entry.bht_dec   = upd_bht_dec;
    wr_entry.btb_en    = upd_btb_en;
    wr_entry.btb_index = upd_btb_index;
    wr_entry.btb_wmask = upd_btb_wmask;
    wr_entry.btb_din   = upd_btb_din;
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy and starvation counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      // QDEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (grant) rd_ptr <= rd_ptr + PW'(1);

      case ({push, grant})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // Counts cycles an update has been held off by fetch. When it reaches
      // LIMIT the next cycle is a forced grant, which clears it again.
      if (grant || !not_empty) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

  // NOTE: the payload storage has no reset; an entry is only ever read after
  // it has been written, and the pointers/count are what reset clears.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // ---------------------------------------------------------------------------
  // Write-port drive: everything is zero unless the head is being issued.
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the conditional so no latch is
  // inferred and nothing is left undriven in non-grant cycles.
  always_comb begin
    bht_write_enable         = 1'b0;
    bht_write_index          = '0;
    bht_write_counter_select = '0;
    bht_write_inc            = 1'b0;
    bht_write_dec            = 1'b0;
    bht_valid_in             = 1'b0;
    btb_ce                   = 1'b0;
    btb_we                   = 1'b0;
    btb_wmask                = '0;
    btb_write_index          = '0;
    btb_din                  = '0;

    if (grant) begin
      // A head with both enables low is still popped, just without strobes.
      bht_write_enable         = head.bht_en;
      bht_valid_in             = head.bht_en;
      bht_write_index          = head.bht_index;
      bht_write_counter_select = head.bht_sel;
      // inc and dec are forwarded as-is even when both are set.
      bht_write_inc            = head.bht_inc;
      bht_write_dec            = head.bht_dec;
      btb_ce                   = head.btb_en;
      btb_we                   = head.btb_en;
      btb_write_index          = head.btb_index;
      btb_wmask                = head.btb_wmask;
      btb_din                  = head.btb_din;
    end
  end

endmodule
